// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the memory stage.
//   LSU_*    : load/store access types (funct3 encoding)
//   DEST_MEM : writeback-source code that marks a load
//   lsu_state_t : memory-stage LSU FSM encoding
package riscv_pkg;
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] DEST_MEM = 2'b01;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the memory-stage LSU.
//   op, offset, access, rs2 -> be, wdata, misalign  (request side)
//   rd_op, rd_offset, rdata -> rdata_ext             (response side)
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic        access,
    input  logic [31:0] rs2,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    input  logic [2:0]  rd_op,
    input  logic [1:0]  rd_offset,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);
    logic        bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        bad   = 1'b0;
        case (op)
            LSU_B, LSU_BU: begin
                be    = 4'b0001 << offset;
                wdata = {4{rs2[7:0]}};
            end
            LSU_H, LSU_HU: begin
                be    = offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2[15:0]}};
                bad   = offset[0];
            end
            LSU_W: begin
                be    = 4'b1111;
                wdata = rs2;
                bad   = |offset;
            end
            default: bad = 1'b1;    // 011/110/111 are not valid access types
        endcase
    end

    // Only an actual access can be misaligned; a flushed slot never flags.
    assign misalign = access & bad;

    assign byte_sel = rdata[{rd_offset, 3'b000} +: 8];
    assign half_sel = rd_offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (rd_op)
            LSU_B:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            LSU_BU:  rdata_ext = {24'h0, byte_sel};
            LSU_H:   rdata_ext = {{16{half_sel[15]}}, half_sel};
            LSU_HU:  rdata_ext = {16'h0, half_sel};
            default: rdata_ext = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Turns the held EX/MEM fields into a single
// req/ack data-memory transaction and stalls earlier stages while it runs.
//   inputs : alu_result_i (address), rs2_i (store data), lsu_op_i, data_dest_i,
//            mem_wr_sig_i, dmem_ack_i, dmem_rdata_i
//   outputs: dmem_req/we/addr/be/wdata_o (registered bus), load_data_o,
//            load_valid_o (pulse), stall_o, misalign_o (combinational)
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [31:0]       rs2_i,
    input  logic [2:0]        lsu_op_i,
    input  logic [1:0]        data_dest_i,
    input  logic              mem_wr_sig_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic [31:0]       dmem_rdata_i,
    output logic [31:0]       load_data_o,
    output logic              load_valid_o,
    output logic              stall_o,
    output logic              misalign_o
);
    lsu_state_t  state;
    logic        access;
    logic        is_load_q;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ext_c;

    assign access = (data_dest_i == DEST_MEM) | mem_wr_sig_i;

    lsu_align u_align (
        .op        (lsu_op_i),
        .offset    (alu_result_i[1:0]),
        .access    (access),
        .rs2       (rs2_i),
        .be        (be_c),
        .wdata     (wdata_c),
        .misalign  (misalign_o),
        .rd_op     (op_q),
        .rd_offset (off_q),
        .rdata     (dmem_rdata_i),
        .rdata_ext (ext_c)
    );

    // The detect cycle stalls combinationally so EX/MEM holds the instruction
    // while the bus registers load; DONE releases the pipeline.
    assign stall_o = (state == LSU_BUSY) |
                     ((state == LSU_IDLE) & access & ~misalign_o);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LSU_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= 4'b0000;
            dmem_wdata_o <= 32'h0;
            load_data_o  <= 32'h0;
            load_valid_o <= 1'b0;
            is_load_q    <= 1'b0;
            op_q         <= 3'b000;
            off_q        <= 2'b00;
        end else begin
            case (state)
                LSU_IDLE: begin
                    load_valid_o <= 1'b0;
                    if (access && !misalign_o) begin
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_wr_sig_i;
                        dmem_addr_o  <= {alu_result_i[ADDR_W-1:2], 2'b00};
                        dmem_be_o    <= be_c;
                        dmem_wdata_o <= wdata_c;
                        is_load_q    <= ~mem_wr_sig_i;   // store wins when both set
                        op_q         <= lsu_op_i;
                        off_q        <= alu_result_i[1:0];
                        state        <= LSU_BUSY;
                    end
                end
                LSU_BUSY: begin
                    if (dmem_ack_i) begin
                        dmem_req_o   <= 1'b0;
                        dmem_we_o    <= 1'b0;
                        dmem_addr_o  <= '0;
                        dmem_be_o    <= 4'b0000;
                        dmem_wdata_o <= 32'h0;
                        if (is_load_q) begin
                            load_data_o  <= ext_c;
                            load_valid_o <= 1'b1;
                        end
                        state <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    // Inputs still show the retiring instruction; don't resample.
                    load_valid_o <= 1'b0;
                    state        <= LSU_IDLE;
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result_i;
    logic [31:0] rs2_i;
    logic [2:0]  lsu_op_i;
    logic [1:0]  data_dest_i;
    logic        mem_wr_sig_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        stall_o;
    logic        misalign_o;

    int total = 0;
    int bad = 0;

    // Values observed during one transaction
    int          n_stall;
    logic        b_req, b_we, d_req, d_stall, d_lv, n_lv;
    logic [31:0] b_addr, b_wdata, d_ld;
    logic [3:0]  b_be;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result_i (alu_result_i),
        .rs2_i        (rs2_i),
        .lsu_op_i     (lsu_op_i),
        .data_dest_i  (data_dest_i),
        .mem_wr_sig_i (mem_wr_sig_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .stall_o      (stall_o),
        .misalign_o   (misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_result_i = 32'h0;
        rs2_i        = 32'h0;
        lsu_op_i     = 3'b000;
        data_dest_i  = 2'b00;
        mem_wr_sig_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in an IDLE cycle, ack after `wait_cyc` extra
    // BUSY cycles with `rdata`, and record what the bus and stall did.
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] data, input logic store,
                              input int wait_cyc, input logic [31:0] rdata);
        lsu_op_i     = op;
        alu_result_i = addr;
        rs2_i        = data;
        mem_wr_sig_i = store;
        data_dest_i  = store ? 2'b00 : 2'b01;
        #1;
        n_stall = int'(stall_o);
        tick();
        b_req = dmem_req_o; b_we = dmem_we_o; b_addr = dmem_addr_o;
        b_be = dmem_be_o; b_wdata = dmem_wdata_o;
        n_stall += int'(stall_o);
        for (int i = 0; i < wait_cyc; i++) begin
            tick();
            n_stall += int'(stall_o);
        end
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = rdata;
        tick();
        dmem_ack_i = 1'b0;
        d_req = dmem_req_o; d_stall = stall_o; d_lv = load_valid_o; d_ld = load_data_o;
        clear_inputs();
        tick();
        n_lv = load_valid_o;
    endtask

    initial begin
        clear_inputs();
        dmem_ack_i   = 1'b0;
        dmem_rdata_i = 32'h0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("rst_we",    {31'h0, dmem_we_o}, 32'h0);
        chk("rst_addr",  dmem_addr_o, 32'h0);
        chk("rst_be",    {28'h0, dmem_be_o}, 32'h0);
        chk("rst_wdata", dmem_wdata_o, 32'h0);
        chk("rst_ld",    load_data_o, 32'h0);
        chk("rst_lv",    {31'h0, load_valid_o}, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // SW 0x100, zero-wait
        run_access(3'b010, 32'h100, 32'hDEADBEEF, 1'b1, 0, 32'h0);
        chk("sw_req",   {31'h0, b_req}, 32'h1);
        chk("sw_we",    {31'h0, b_we}, 32'h1);
        chk("sw_addr",  b_addr, 32'h100);
        chk("sw_be",    {28'h0, b_be}, 32'hF);
        chk("sw_wdata", b_wdata, 32'hDEADBEEF);
        chk("sw_stall_cycles", n_stall, 2);
        chk("sw_done_stall", {31'h0, d_stall}, 32'h0);
        chk("sw_done_req", {31'h0, d_req}, 32'h0);
        chk("sw_no_lv", {31'h0, d_lv}, 32'h0);

        // SB 0x103
        run_access(3'b000, 32'h103, 32'h000000A5, 1'b1, 0, 32'h0);
        chk("sb_addr",  b_addr, 32'h100);
        chk("sb_be",    {28'h0, b_be}, 32'h8);
        chk("sb_wdata", b_wdata, 32'hA5A5A5A5);

        // LB / LBU 0x103
        run_access(3'b000, 32'h103, 32'h0, 1'b0, 0, 32'h80112233);
        chk("lb_we",   {31'h0, b_we}, 32'h0);
        chk("lb_be",   {28'h0, b_be}, 32'h8);
        chk("lb_lv",   {31'h0, d_lv}, 32'h1);
        chk("lb_data", d_ld, 32'hFFFFFF80);
        chk("lb_lv_pulse", {31'h0, n_lv}, 32'h0);
        chk("lb_hold", load_data_o, 32'hFFFFFF80);
        run_access(3'b100, 32'h103, 32'h0, 1'b0, 0, 32'h80112233);
        chk("lbu_data", d_ld, 32'h00000080);

        // LH / LHU 0x102, the LHU with a three-cycle ack delay
        run_access(3'b001, 32'h102, 32'h0, 1'b0, 0, 32'h80017FFF);
        chk("lh_be",   {28'h0, b_be}, 32'hC);
        chk("lh_data", d_ld, 32'hFFFF8001);
        run_access(3'b101, 32'h102, 32'h0, 1'b0, 3, 32'h80017FFF);
        chk("lhu_data", d_ld, 32'h00008001);
        chk("lhu_stall_cycles", n_stall, 5);
        chk("lhu_lv", {31'h0, d_lv}, 32'h1);

        // LW 0x101: misaligned
        lsu_op_i = 3'b010; alu_result_i = 32'h101; data_dest_i = 2'b01;
        #1;
        chk("lw_mis_flag",  {31'h0, misalign_o}, 32'h1);
        chk("lw_mis_stall", {31'h0, stall_o}, 32'h0);
        tick();
        chk("lw_mis_req",   {31'h0, dmem_req_o}, 32'h0);
        tick();
        chk("lw_mis_lv",    {31'h0, load_valid_o}, 32'h0);
        // op 111 load: illegal
        lsu_op_i = 3'b111; alu_result_i = 32'h100;
        #1;
        chk("ill_flag",  {31'h0, misalign_o}, 32'h1);
        chk("ill_stall", {31'h0, stall_o}, 32'h0);
        tick();
        chk("ill_req",   {31'h0, dmem_req_o}, 32'h0);
        clear_inputs();
        #1;
        chk("flush_no_mis", {31'h0, misalign_o}, 32'h0);
        tick();

        // Reset in the middle of a load's BUSY phase
        lsu_op_i = 3'b010; alu_result_i = 32'h200; data_dest_i = 2'b01;
        tick();
        chk("rb_req_busy", {31'h0, dmem_req_o}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rb_req_drop", {31'h0, dmem_req_o}, 32'h0);
        chk("rb_ld_clear", load_data_o, 32'h0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h12345678;
        tick();
        dmem_ack_i = 1'b0;
        chk("rb_late_lv",  {31'h0, load_valid_o}, 32'h0);
        chk("rb_late_ld",  load_data_o, 32'h0);
        chk("rb_late_req", {31'h0, dmem_req_o}, 32'h0);

        // Flushed slot with a spurious ack
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
        #1;
        chk("fl_stall", {31'h0, stall_o}, 32'h0);
        tick();
        dmem_ack_i = 1'b0;
        chk("fl_req",   {31'h0, dmem_req_o}, 32'h0);
        chk("fl_lv",    {31'h0, load_valid_o}, 32'h0);
        chk("fl_stall2", {31'h0, stall_o}, 32'h0);

        // A real load still works afterwards, proving the FSM stayed in IDLE
        run_access(3'b010, 32'h204, 32'h0, 1'b0, 0, 32'h0BADF00D);
        chk("post_addr", b_addr, 32'h204);
        chk("post_data", d_ld, 32'h0BADF00D);
        chk("post_stall_cycles", n_stall, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
